// File: rtl/nco_clk_gen_pkg.sv
// rtl/nco_clk_gen_pkg.sv - shared types, defaults and helpers for the NCO clock-enable generator
package nco_clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } nco_state_e;

  localparam int ACC_W_DEFAULT         = 32;
  localparam int SETTLE_CYCLES_DEFAULT = 16;

  // Rounded phase increment giving f_out_hz from f_ref_hz with an acc_w-bit accumulator
  function automatic longint unsigned freq_to_inc(input longint unsigned f_ref_hz,
                                                  input longint unsigned f_out_hz,
                                                  input int acc_w = ACC_W_DEFAULT);
    return ((f_out_hz << acc_w) + (f_ref_hz >> 1)) / f_ref_hz;
  endfunction

endpackage

// File: rtl/nco_clk_gen_channel.sv
// rtl/nco_clk_gen_channel.sv - one phase accumulator with load/run/hold control
module nco_channel
  import nco_clk_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             clk_en,
  output logic             outclk
);

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // Load aligns the channel to its start phase; run advances it; otherwise hold with no enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      inc    <= '0;
      acc    <= '0;
      clk_en <= 1'b0;
      outclk <= 1'b0;
    end else if (load) begin
      inc    <= load_inc;
      acc    <= load_phase;
      clk_en <= 1'b0;
      outclk <= load_phase[ACC_W-1];
    end else if (run) begin
      acc    <= sum[ACC_W-1:0];
      clk_en <= sum[ACC_W];
      outclk <= sum[ACC_W-1];
    end else begin
      clk_en <= 1'b0;
    end
  end

endmodule

// File: rtl/nco_clk_gen.sv
// rtl/nco_clk_gen.sv - multi-channel NCO clock-enable generator with aligned restart and lock
module nco_clk_gen
  import nco_clk_gen_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int ACC_W         = ACC_W_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_ALIGN  = 2'(ALIGN);
  localparam logic [1:0] S_SETTLE = 2'(SETTLE);
  localparam logic [1:0] S_LOCKED = 2'(LOCKED);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0] shadow_inc   [NUM_CH];
  logic [ACC_W-1:0] shadow_phase [NUM_CH];
  logic [ACC_W-1:0] load_inc     [NUM_CH];
  logic [ACC_W-1:0] load_phase   [NUM_CH];

  logic ch_load;
  logic ch_run;

  assign ch_load = (state == S_ALIGN);
  assign ch_run  = (state == S_SETTLE) || (state == S_LOCKED);

  // Shadow config: written by cfg_we, channel numbers past NUM_CH match nothing
  always_ff @(posedge refclk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_inc[i]   <= '0;
        shadow_phase[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          shadow_inc[i]   <= cfg_inc;
          shadow_phase[i] <= cfg_phase;
        end
      end
    end
  end

  // Load values: a write landing in the same cycle overrides the stored shadow
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      load_inc[i]   = shadow_inc[i];
      load_phase[i] = shadow_phase[i];
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        load_inc[i]   = cfg_inc;
        load_phase[i] = cfg_phase;
      end
    end
  end

  // Restart sequencing: apply always forces ALIGN; lock only after a full undisturbed settle
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        S_ALIGN: begin
          state  <= S_SETTLE;
          cnt    <= '0;
          locked <= 1'b0;
        end
        S_SETTLE: begin
          if (cnt == CNT_LAST && !cfg_apply) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (cfg_apply) begin
        state <= S_ALIGN;
        cnt   <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    nco_channel #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk        (refclk),
      .rst        (rst),
      .load       (ch_load),
      .run        (ch_run),
      .load_inc   (load_inc[g]),
      .load_phase (load_phase[g]),
      .clk_en     (clk_en[g]),
      .outclk     (outclk[g])
    );
  end

endmodule

// File: tb/tb_nco_clk_gen.sv
// tb/tb_nco_clk_gen.sv - directed self-checking bench for nco_clk_gen
module tb_nco_clk_gen;
  import nco_clk_gen_pkg::*;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 32;
  localparam int SETTLE = 16;

  logic              refclk    = 1'b0;
  logic              rst       = 1'b0;
  logic              cfg_we    = 1'b0;
  logic [1:0]        cfg_ch    = '0;
  logic [ACC_W-1:0]  cfg_inc   = '0;
  logic [ACC_W-1:0]  cfg_phase = '0;
  logic              cfg_apply = 1'b0;
  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] outclk;
  logic              locked;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] en_mask [NUM_CH];
  logic [31:0] oc_mask [NUM_CH];
  logic [31:0] lk_mask;
  int          en_cnt  [NUM_CH];
  int          oc_cnt  [NUM_CH];
  int          lk_cnt;
  int          any_en;
  int          got_rng;

  nco_clk_gen #(
    .NUM_CH        (NUM_CH),
    .ACC_W         (ACC_W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .cfg_apply (cfg_apply),
    .clk_en    (clk_en),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge refclk);
  endtask

  // Record outputs after each of the next n edges as bit m-1 of per-signal masks
  task automatic collect(input int n);
    for (int c = 0; c < NUM_CH; c++) begin
      en_mask[c] = '0;
      oc_mask[c] = '0;
    end
    lk_mask = '0;
    for (int m = 0; m < n; m++) begin
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        en_mask[c][m] = clk_en[c];
        oc_mask[c][m] = outclk[c];
      end
      lk_mask[m] = locked;
    end
  endtask

  task automatic count(input int n);
    for (int c = 0; c < NUM_CH; c++) begin
      en_cnt[c] = 0;
      oc_cnt[c] = 0;
    end
    lk_cnt = 0;
    for (int m = 0; m < n; m++) begin
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        en_cnt[c] += int'(clk_en[c]);
        oc_cnt[c] += int'(outclk[c]);
      end
      lk_cnt += int'(locked);
    end
  endtask

  task automatic write_cfg(input int ch, input logic [31:0] inc, input logic [31:0] phase,
                           input logic with_apply);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_inc   = inc;
    cfg_phase = phase;
    cfg_apply = with_apply;
    tick();
    cfg_we    = 1'b0;
    cfg_apply = 1'b0;
  endtask

  task automatic apply(input int n);
    cfg_apply = 1'b1;
    repeat (n) tick();
    cfg_apply = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with random config traffic
    rst = 1'b0;
    repeat (3) begin
      cfg_we    = 1'($urandom);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_inc   = $urandom;
      cfg_phase = $urandom;
      cfg_apply = 1'($urandom);
      tick();
    end
    check_eq("rst_clk_en", 64'(clk_en), 64'd0);
    check_eq("rst_outclk", 64'(outclk), 64'd0);
    check_eq("rst_locked", 64'(locked), 64'd0);
    check_eq("rst_state", 64'(dut.state), 64'(IDLE));
    cfg_we = 1'b0;
    cfg_apply = 1'b0;
    rst = 1'b1;
    count(10);
    any_en = en_cnt[0] + en_cnt[1] + en_cnt[2];
    check_eq("idle_no_en", 64'(any_en), 64'd0);
    check_eq("idle_locked", 64'(lk_cnt), 64'd0);
    check_eq("idle_state", 64'(dut.state), 64'(IDLE));

    // Apply with shadows cleared by reset: nothing runs, lock still comes
    apply(1);
    collect(17);
    check_eq("clr_en", 64'(en_mask[0] | en_mask[1] | en_mask[2]), 64'h0);
    check_eq("clr_lock", 64'(lk_mask), 64'h10000);

    // Basic rates
    write_cfg(0, 32'h8000_0000, 32'h0, 1'b0);
    write_cfg(1, 32'h4000_0000, 32'h0, 1'b0);
    apply(1);
    collect(17);
    check_eq("rate_en0", 64'(en_mask[0]), 64'h15554);
    check_eq("rate_en1", 64'(en_mask[1]), 64'h11110);
    check_eq("rate_oc0", 64'(oc_mask[0]), 64'h0AAAA);
    check_eq("rate_oc1", 64'(oc_mask[1]), 64'h0CCCC);
    check_eq("rate_lock", 64'(lk_mask), 64'h10000);

    // Phase alignment
    write_cfg(0, 32'h4000_0000, 32'h0, 1'b0);
    write_cfg(1, 32'h4000_0000, 32'h8000_0000, 1'b0);
    apply(1);
    collect(17);
    check_eq("phase_en0", 64'(en_mask[0]), 64'h11110);
    check_eq("phase_en1", 64'(en_mask[1]), 64'h04444);
    check_eq("phase_oc0", 64'(oc_mask[0]), 64'h0CCCC);
    check_eq("phase_oc1", 64'(oc_mask[1]), 64'h13333);
    check_eq("phase_lock", 64'(lk_mask), 64'h10000);

    // Shadow isolation
    write_cfg(0, 32'h2000_0000, 32'h0, 1'b0);
    count(100);
    check_eq("iso_en0_cnt", 64'(en_cnt[0]), 64'd25);
    check_eq("iso_lock_cnt", 64'(lk_cnt), 64'd100);
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
    check_eq("iso_lock_at_apply", 64'(locked), 64'd1);
    collect(17);
    check_eq("iso_en0", 64'(en_mask[0]), 64'h10100);
    check_eq("iso_lock", 64'(lk_mask), 64'h10000);
    count(80);
    check_eq("iso_en0_cnt8", 64'(en_cnt[0]), 64'd10);

    // Write-through on the apply cycle
    write_cfg(0, 32'h8000_0000, 32'h0, 1'b1);
    collect(17);
    check_eq("wt_en0", 64'(en_mask[0]), 64'h15554);
    check_eq("wt_en1", 64'(en_mask[1]), 64'h04444);
    check_eq("wt_lock", 64'(lk_mask), 64'h10000);

    // Out-of-range channel write is ignored
    write_cfg(3, 32'h1000_0000, 32'h1234_5678, 1'b1);
    collect(17);
    check_eq("ign_en0", 64'(en_mask[0]), 64'h15554);
    check_eq("ign_en1", 64'(en_mask[1]), 64'h04444);
    check_eq("ign_en2", 64'(en_mask[2]), 64'h0);
    check_eq("ign_oc2", 64'(oc_mask[2]), 64'h0);

    // Multi-cycle apply: lock counts from the last asserted cycle
    apply(3);
    collect(17);
    check_eq("multi_lock", 64'(lk_mask), 64'h10000);
    check_eq("multi_en0", 64'(en_mask[0]), 64'h15554);

    // Long run at a 50 MHz reference
    check_eq("inc_1mhz", 64'(freq_to_inc(50_000_000, 1_000_000, 32)), 64'd85899346);
    check_eq("inc_24mhz", 64'(freq_to_inc(50_000_000, 24_000_000, 32)), 64'd2061584302);
    write_cfg(0, 32'd85899346, 32'h0, 1'b0);
    write_cfg(1, 32'd2061584302, 32'h0, 1'b0);
    write_cfg(2, 32'h0, 32'h8000_0000, 1'b0);
    apply(1);
    collect(17);
    check_eq("long_lock", 64'(lk_mask), 64'h10000);
    count(20000);
    got_rng = (en_cnt[0] >= 399 && en_cnt[0] <= 401) ? 400 : en_cnt[0];
    check_eq("long_en0_cnt", 64'(got_rng), 64'd400);
    got_rng = (en_cnt[1] >= 9599 && en_cnt[1] <= 9601) ? 9600 : en_cnt[1];
    check_eq("long_en1_cnt", 64'(got_rng), 64'd9600);
    check_eq("long_en2_cnt", 64'(en_cnt[2]), 64'd0);
    check_eq("long_oc2_cnt", 64'(oc_cnt[2]), 64'd20000);
    check_eq("long_lock_cnt", 64'(lk_cnt), 64'd20000);

    // Reset mid-operation
    rst = 1'b0;
    tick();
    check_eq("midrst_out", 64'({clk_en, outclk, locked}), 64'd0);
    check_eq("midrst_shadow", 64'(dut.shadow_inc[1]), 64'd0);
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
